div: RTL and testbench

Sequential restoring divider: the inverse of the team's shift-add multiplier (`mul`), with the same start/fin handshake. It latches an unsigned dividend and divisor on `start` and produces one quotient bit per clock, MSB first. It then presents the quotient and remainder with a one-cycle `fin` pulse. It sits beside `mul` in the arithmetic datapath and is driven by the same controller.

---
 rtl/arith_pkg.sv | 14 +
 rtl/div_step.sv | 31 +++
 rtl/div.sv | 146 ++++++++++++++
 tb/tb_div.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types and default widths
// Used by div (and mul): state encoding for the sequential arithmetic units
// and the default operand widths.
package arith_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } div_state_e;

    localparam int DIV_DW = 16;
    localparam int DIV_VW = 8;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division trial subtract (combinational)
// Ports:
//   p      in  VW+1 : current partial remainder
//   a_bit  in  1    : next dividend bit shifted in
//   bin    in  VW   : divisor
//   p_next out VW+1 : partial remainder after this step
//   qbit   out 1    : quotient bit produced by this step
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   p,
    input  logic          a_bit,
    input  logic [VW-1:0] bin,
    output logic [VW:0]   p_next,
    output logic          qbit
);

    localparam int PW = VW + 1;

    // The remainder's MSB is always 0 after a real step (P < BIN), so the
    // wider shift is equivalent to {P[VW-1:0], a_bit}; with BIN=0 the cast
    // drops the same bit the narrow form would.
    logic [VW+1:0] t;

    always_comb begin
        t      = {p, a_bit};
        qbit   = (t >= {2'b00, bin});
        p_next = qbit ? PW'(t - {2'b00, bin}) : PW'(t);
    end

endmodule

// File: rtl/div.sv
// rtl/div.sv - sequential restoring divider, one quotient bit per clock
// Optional feature macro: DIV_ZERO_CHECK_EN (early finish with dz on B=0).
// Ports:
//   ck     in  1  : clock
//   rst_n  in  1  : asynchronous active-low reset
//   start  in  1  : load A/B and begin (restarts an active division)
//   A      in  DW : dividend
//   B      in  VW : divisor
//   Q      out DW : quotient, held until next completion
//   R      out VW : remainder, held until next completion
//   fin    out 1  : one-cycle completion pulse
//   busy   out 1  : division in progress
//   dz     out 1  : divide-by-zero flag, valid with fin
module div
    import arith_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          fin,
    output logic          busy,
    output logic          dz
);

    localparam int SW = $clog2(DW);

    div_state_e    state_q, state_d;
    logic [DW-1:0] ain_q, ain_d;
    logic [VW-1:0] bin_q, bin_d;
    logic [VW:0]   p_q, p_d;
    logic [SW-1:0] st_q, st_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          fin_q, fin_d;
    logic          busy_q, busy_d;

    logic [VW:0]   p_step;
    logic          q_bit;
    logic          zero_skip;

    div_step #(.VW(VW)) u_step (
        .p      (p_q),
        .a_bit  (ain_q[DW-1]),
        .bin    (bin_q),
        .p_next (p_step),
        .qbit   (q_bit)
    );

`ifdef DIV_ZERO_CHECK_EN
    logic dz_q, dz_d;
    assign zero_skip = (bin_q == '0);
    assign dz        = dz_q;
`else
    assign zero_skip = 1'b0;
    assign dz        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        p_d     = p_q;
        st_d    = st_q;
        q_d     = q_q;
        r_d     = r_q;
        fin_d   = 1'b0;
        busy_d  = busy_q;
`ifdef DIV_ZERO_CHECK_EN
        dz_d    = 1'b0;
`endif
        if (start) begin
            ain_d   = A;
            bin_d   = B;
            p_d     = '0;
            st_d    = '0;
            state_d = S_RUN;
            busy_d  = 1'b1;
        end else if (state_q == S_RUN) begin
            if (zero_skip) begin
                // ain_q still holds the untouched dividend on the first RUN cycle
                q_d     = '1;
                r_d     = ain_q[VW-1:0];
                fin_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef DIV_ZERO_CHECK_EN
                dz_d    = 1'b1;
`endif
            end else begin
                p_d   = p_step;
                ain_d = {ain_q[DW-2:0], q_bit};
                st_d  = st_q + SW'(1);
                if (st_q == SW'(DW - 1)) begin
                    q_d     = {ain_q[DW-2:0], q_bit};
                    r_d     = p_step[VW-1:0];
                    fin_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ain_q   <= '0;
            bin_q   <= '0;
            p_q     <= '0;
            st_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            p_q     <= p_d;
            st_q    <= st_d;
            q_q     <= q_d;
            r_q     <= r_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
`ifdef DIV_ZERO_CHECK_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign fin  = fin_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed and random self-checking bench for div
module tb_div;
    import arith_pkg::*;

    localparam int DW = DIV_DW;
    localparam int VW = DIV_VW;
`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic          ck = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [VW-1:0] b_in = '0;
    logic [DW-1:0] q_out;
    logic [VW-1:0] r_out;
    logic          fin, busy, dz;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] prev_q = '0;
    logic [VW-1:0] prev_r = '0;

    div dut (
        .ck    (ck),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Q     (q_out),
        .R     (r_out),
        .fin   (fin),
        .busy  (busy),
        .dz    (dz)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge on which fin is observed.
    task automatic run_div(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [DW-1:0] eq, input logic [VW-1:0] er,
                           input logic edz, input int elat);
        int n;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge ck);
        start = 1'b0;
        a_in  = DW'($urandom);
        b_in  = VW'($urandom);
        n = 0;
        chk({tag, "_busy_run"}, busy, 1);
        chk({tag, "_fin_run"}, fin, 0);
        chk({tag, "_q_hold"}, q_out, prev_q);
        chk({tag, "_r_hold"}, r_out, prev_r);
        while (!fin && n < 40) begin
            @(negedge ck);
            n++;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_q"}, q_out, eq);
        chk({tag, "_r"}, r_out, er);
        chk({tag, "_dz"}, dz, edz);
        chk({tag, "_busy_done"}, busy, 0);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int nfin, idx;
        logic [DW-1:0] cq;
        logic [VW-1:0] cr;
        int ra, rb;

        repeat (2) @(negedge ck);
        chk("rst_q", q_out, 0);
        chk("rst_r", r_out, 0);
        chk("rst_fin", fin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dz", dz, 0);
        rst_n = 1'b1;
        @(negedge ck);

        run_div("d200_7", 200, 7, 28, 4, 1'b0, 16);
        @(negedge ck);
        chk("fin_drop", fin, 0);

        // back-to-back: start issued in the fin cycle
        run_div("d65535_255", 65535, 255, 257, 0, 1'b0, 16);
        run_div("d5_9", 5, 9, 0, 5, 1'b0, 16);
        run_div("d65535_1", 65535, 1, 65535, 0, 1'b0, 16);
        run_div("d0_5", 0, 5, 0, 0, 1'b0, 16);
        run_div("d255_255", 255, 255, 1, 0, 1'b0, 16);

        run_div("d1234_0", 1234, 0, 16'hFFFF, 210, ZC, ZC ? 1 : 16);
        @(negedge ck);
        chk("dz_clear", dz, 0);
        chk("dz_fin_clear", fin, 0);

        // abort and restart mid-division
        nfin = 0;
        idx = -1;
        cq = '0;
        cr = '0;
        start = 1'b1; a_in = 1000; b_in = 3;
        @(negedge ck);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            if (fin) nfin++;
        end
        start = 1'b1; a_in = 100; b_in = 10;
        @(negedge ck);
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge ck);
            if (fin) begin
                nfin++;
                idx = i;
                cq = q_out;
                cr = r_out;
            end
        end
        chk("restart_nfin", nfin, 1);
        chk("restart_lat", idx, 16);
        chk("restart_q", cq, 10);
        chk("restart_r", cr, 0);
        prev_q = 10;
        prev_r = 0;

        run_div("d255_4", 255, 4, 63, 3, 1'b0, 16);

        // asynchronous reset in the middle of a division
        @(negedge ck);
        start = 1'b1; a_in = 200; b_in = 7;
        @(negedge ck);
        start = 1'b0;
        repeat (5) @(negedge ck);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_fin", fin, 0);
        chk("arst_q", q_out, 0);
        chk("arst_r", r_out, 0);
        @(negedge ck);
        rst_n = 1'b1;
        nfin = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge ck);
            if (fin) nfin++;
        end
        chk("arst_no_fin", nfin, 0);
        prev_q = '0;
        prev_r = '0;

        // random sweep, back-to-back
        for (int i = 0; i < 300; i++) begin
            ra = int'($urandom_range(0, 65535));
            rb = int'($urandom_range(1, 255));
            run_div("rnd", DW'(ra), VW'(rb), DW'(ra / rb), VW'(ra % rb), 1'b0, 16);
        end
        @(negedge ck);
        chk("rnd_fin_drop", fin, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
